// File: rtl/luna_clk_pkg.sv
// rtl/luna_clk_pkg.sv - shared types and constants for the clock step controller
package luna_clk_pkg;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } step_state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
    localparam int          STEP_COUNT_W     = 16;

    // Counter width for a debounce window, never narrower than one bit.
    function automatic int debounce_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/clock_step_controller_if.sv
// rtl/clock_step_controller_if.sv - tick, button, halt and clock-enable signal bundle
interface clock_step_controller_if;
    import luna_clk_pkg::*;

    logic                    tick_in;
    logic                    btn_step;
    logic                    btn_mode;
    logic                    halt_req;
    logic                    cpu_ce;
    logic                    running;
    logic [STEP_COUNT_W-1:0] step_count;

    modport master (
        output tick_in, btn_step, btn_mode, halt_req,
        input  cpu_ce, running, step_count
    );

    modport slave (
        input  tick_in, btn_step, btn_mode, halt_req,
        output cpu_ce, running, step_count
    );

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizes and debounces one pushbutton, pulses on press
module button_debouncer
    import luna_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CNT_W   = debounce_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // The stable level only moves after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_step_controller.sv
// rtl/clock_step_controller.sv - RUN/HALT single-step control of the CPU clock enable
module clock_step_controller
    import luna_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst,
    clock_step_controller_if.slave   bus
);

    step_state_t             state;
    step_state_t             state_next;
    logic                    ce_next;
    logic                    cpu_ce_q;
    logic [STEP_COUNT_W-1:0] step_count_q;

    logic tick_sync1;
    logic tick_sync2;
    logic tick_hist;
    logic tick_rise;
    logic tick_evt;
    logic step_press;
    logic mode_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk_in (clk_in),
        .rst    (rst),
        .btn    (bus.btn_step),
        .press  (step_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk_in (clk_in),
        .rst    (rst),
        .btn    (bus.btn_mode),
        .press  (mode_press)
    );

    assign tick_rise = tick_sync2 & ~tick_hist;

    // tick_evt retimes the edge so a tick lands on cpu_ce three edges after it is first sampled.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick_sync1 <= 1'b0;
            tick_sync2 <= 1'b0;
            tick_hist  <= 1'b0;
            tick_evt   <= 1'b0;
        end else begin
            tick_sync1 <= bus.tick_in;
            tick_sync2 <= tick_sync1;
            tick_hist  <= tick_sync2;
            tick_evt   <= tick_rise;
        end
    end

    always_comb begin
        state_next = state;
        ce_next    = 1'b0;
        case (state)
            HALT: begin
                if (mode_press && !bus.halt_req) begin
                    state_next = RUN;
                end else if (step_press) begin
                    ce_next = 1'b1;
                end
            end
            RUN: begin
                if (mode_press || bus.halt_req) begin
                    state_next = HALT;
                end else if (tick_evt) begin
                    ce_next = 1'b1;
                end
            end
            default: state_next = HALT;
        endcase
        // Back-to-back enables would double-clock the CPU; drop the second one.
        if (cpu_ce_q) begin
            ce_next = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= HALT;
            cpu_ce_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state    <= state_next;
            cpu_ce_q <= ce_next;
            if (cpu_ce_q) begin
                step_count_q <= step_count_q + STEP_COUNT_W'(1);
            end
        end
    end

    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.running    = (state == RUN);
    assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// tb/tb_clock_step_controller.sv - directed bench with a cycle model of the step controller
module tb_clock_step_controller;

    localparam int D = 4;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_in = ~clk_in;

    clock_step_controller_if bus_if ();

    clock_step_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ce_seen  = 0;
    int ce0      = 0;
    logic prev_ce = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: every input event reaches the decision point three edges after
    // its sample (tick edge, or D-th consecutive changed button sample).
    logic        m_tick_prev;
    logic [2:0]  m_tick_d, m_step_d, m_mode_d;
    logic        m_step_st, m_mode_st;
    int          m_step_run, m_mode_run;
    logic        m_run, m_ce, m_pulse;
    logic        t_use, s_use, md_use, s_ev, md_ev;
    logic [15:0] m_count;

    task automatic btn_model(input logic raw, input logic st_in, input int run_in,
                             output logic st_out, output int run_out, output logic ev);
        st_out  = st_in;
        run_out = 0;
        ev      = 1'b0;
        if (raw != st_in) begin
            run_out = run_in + 1;
            if (run_out == D) begin
                st_out  = raw;
                run_out = 0;
                ev      = raw;
            end
        end
    endtask

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_tick_prev = 1'b0;
            m_tick_d = '0; m_step_d = '0; m_mode_d = '0;
            m_step_st = 1'b0; m_mode_st = 1'b0;
            m_step_run = 0; m_mode_run = 0;
            m_run = 1'b0; m_ce = 1'b0; m_count = 16'd0;
        end else begin
            t_use    = m_tick_d[2];
            m_tick_d = {m_tick_d[1:0], bus_if.tick_in & ~m_tick_prev};
            m_tick_prev = bus_if.tick_in;
            btn_model(bus_if.btn_step, m_step_st, m_step_run, m_step_st, m_step_run, s_ev);
            btn_model(bus_if.btn_mode, m_mode_st, m_mode_run, m_mode_st, m_mode_run, md_ev);
            s_use    = m_step_d[2];
            m_step_d = {m_step_d[1:0], s_ev};
            md_use   = m_mode_d[2];
            m_mode_d = {m_mode_d[1:0], md_ev};
            m_pulse = 1'b0;
            if (!m_run) begin
                if (md_use && !bus_if.halt_req) m_run = 1'b1;
                else if (s_use)                 m_pulse = 1'b1;
            end else begin
                if (md_use || bus_if.halt_req)  m_run = 1'b0;
                else if (t_use)                 m_pulse = 1'b1;
            end
            if (m_ce) begin
                m_pulse = 1'b0;
                m_count = m_count + 16'd1;
            end
            m_ce = m_pulse;
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            #1;
            check("cpu_ce", 32'(bus_if.cpu_ce), 32'(m_ce));
            check("running", 32'(bus_if.running), 32'(m_run));
            check("step_count", 32'(bus_if.step_count), 32'(m_count));
            check("ce_gap", 32'(prev_ce & bus_if.cpu_ce), 32'd0);
            prev_ce = bus_if.cpu_ce;
            if (bus_if.cpu_ce === 1'b1) ce_seen++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic press(input logic s, input logic m);
        bus_if.btn_step = s;
        bus_if.btn_mode = m;
        cyc(6);
        bus_if.btn_step = 1'b0;
        bus_if.btn_mode = 1'b0;
        cyc(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        bus_if.tick_in  = 1'b0;
        bus_if.btn_step = 1'b0;
        bus_if.btn_mode = 1'b0;
        bus_if.halt_req = 1'b0;
        cyc(3);
        #1;
        check("rst_cpu_ce", 32'(bus_if.cpu_ce), 32'd0);
        check("rst_running", 32'(bus_if.running), 32'd0);
        check("rst_step_count", 32'(bus_if.step_count), 32'd0);
        cyc(1);
        rst = 1'b0;

        // Ticks in HALT are ignored
        for (int i = 0; i < 6; i++) begin
            bus_if.tick_in = ~bus_if.tick_in;
            cyc(10);
        end
        bus_if.tick_in = 1'b0;
        #1;
        check("halt_ticks_ce", 32'(ce_seen), 32'd0);
        check("halt_ticks_running", 32'(bus_if.running), 32'd0);
        check("halt_ticks_count", 32'(bus_if.step_count), 32'd0);

        // Bouncy step press: two glitches, then held 6 cycles
        cyc(1);
        ce0 = ce_seen;
        bus_if.btn_step = 1'b1; cyc(1);
        bus_if.btn_step = 1'b0; cyc(1);
        bus_if.btn_step = 1'b1; cyc(1);
        bus_if.btn_step = 1'b0; cyc(1);
        bus_if.btn_step = 1'b1; cyc(6);
        bus_if.btn_step = 1'b0; cyc(12);
        #1;
        check("bounce_pulses", 32'(ce_seen - ce0), 32'd1);
        check("bounce_count", 32'(bus_if.step_count), 32'd1);

        // RUN with five ticks, cpu_ce on the 4th negedge after each tick edge
        cyc(1);
        do_reset();
        press(1'b0, 1'b1);
        #1;
        check("mode_to_run", 32'(bus_if.running), 32'd1);
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            bus_if.tick_in = 1'b1;
            repeat (3) @(negedge clk_in);
            #1;
            check("tick_early", 32'(bus_if.cpu_ce), 32'd0);
            @(negedge clk_in);
            #1;
            check("tick_pulse", 32'(bus_if.cpu_ce), 32'd1);
            bus_if.tick_in = 1'b0;
            cyc(6);
        end
        #1;
        check("run_count5", 32'(bus_if.step_count), 32'd5);

        // halt_req coinciding with tick_rise
        cyc(1);
        bus_if.tick_in = 1'b1;
        cyc(2);
        bus_if.halt_req = 1'b1;
        cyc(1);
        bus_if.halt_req = 1'b0;
        #1;
        check("halt_req_running", 32'(bus_if.running), 32'd0);
        @(negedge clk_in);
        #1;
        check("halt_req_no_pulse", 32'(bus_if.cpu_ce), 32'd0);
        bus_if.tick_in = 1'b0;
        cyc(6);
        #1;
        check("halt_req_count", 32'(bus_if.step_count), 32'd5);

        // Mode press under halt_req stays in HALT
        cyc(1);
        bus_if.halt_req = 1'b1;
        press(1'b0, 1'b1);
        bus_if.halt_req = 1'b0;
        #1;
        check("mode_with_halt", 32'(bus_if.running), 32'd0);

        // Mode and step together: RUN, no pulse; then step ignored in RUN
        cyc(1);
        ce0 = ce_seen;
        press(1'b1, 1'b1);
        #1;
        check("mode_step_running", 32'(bus_if.running), 32'd1);
        check("mode_step_no_pulse", 32'(ce_seen - ce0), 32'd0);
        cyc(1);
        press(1'b1, 1'b0);
        #1;
        check("step_in_run", 32'(ce_seen - ce0), 32'd0);
        cyc(1);
        press(1'b0, 1'b1);
        #1;
        check("mode_to_halt", 32'(bus_if.running), 32'd0);

        // Step with halt_req still steps
        cyc(1);
        ce0 = ce_seen;
        bus_if.halt_req = 1'b1;
        press(1'b1, 1'b0);
        bus_if.halt_req = 1'b0;
        #1;
        check("step_with_halt", 32'(ce_seen - ce0), 32'd1);
        check("step_with_halt_count", 32'(bus_if.step_count), 32'd6);

        // Async reset between tick_rise and cpu_ce
        cyc(1);
        press(1'b0, 1'b1);
        ce0 = ce_seen;
        bus_if.tick_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cpu_ce", 32'(bus_if.cpu_ce), 32'd0);
        check("arst_running", 32'(bus_if.running), 32'd0);
        check("arst_count", 32'(bus_if.step_count), 32'd0);
        bus_if.tick_in = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(8);
        #1;
        check("arst_no_pulse", 32'(ce_seen - ce0), 32'd0);

        // Button held through reset release gives exactly one press
        cyc(1);
        rst = 1'b1;
        bus_if.btn_step = 1'b1;
        cyc(3);
        rst = 1'b0;
        ce0 = ce_seen;
        cyc(12);
        bus_if.btn_step = 1'b0;
        cyc(10);
        #1;
        check("held_rst_pulses", 32'(ce_seen - ce0), 32'd1);
        check("held_rst_count", 32'(bus_if.step_count), 32'd1);

        // Wrap: 65535 steps then one more
        cyc(1);
        do_reset();
        press(1'b0, 1'b1);
        for (int i = 0; i < 65535; i++) begin
            bus_if.tick_in = 1'b1;
            cyc(1);
            bus_if.tick_in = 1'b0;
            cyc(1);
        end
        cyc(8);
        #1;
        check("count_ffff", 32'(bus_if.step_count), 32'h0000ffff);
        cyc(1);
        bus_if.tick_in = 1'b1;
        cyc(1);
        bus_if.tick_in = 1'b0;
        cyc(8);
        #1;
        check("count_wrap", 32'(bus_if.step_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
